// File: rtl/mem_block_arbiter_if.sv
// Bus bundle for mem_block_arbiter: the two cache-controller request ports,
// the shared block-level main-memory port and the arbiter status outputs.
//
// Modports
//   master : arbiter side (consumes requests, drives memory request and status)
//   slave  : environment side (cache controllers + memory model)
//
// Signals
//   req_read/req_write [2]   per-requester level requests, held until req_ready
//   req_addr [2*ADDR_W]      flattened byte addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_write_data [2*BLOCK_W] flattened write lines
//   req_ready [2]            one-cycle completion pulse to the granted requester
//   req_read_data            last line read from memory
//   grant_id                 requester currently or last served
//   busy                     arbiter is not idle
//   mem_read/mem_write       memory request, level
//   mem_addr, mem_write_data block-aligned address and write line
//   mem_read_data, mem_ready memory response
//   timeout_err              watchdog expiry pulse (only with MEM_ARB_TIMEOUT_EN)
interface mem_block_arbiter_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BLOCK_W = 512
);
    logic [1:0]           req_read;
    logic [1:0]           req_write;
    logic [2*ADDR_W-1:0]  req_addr;
    logic [2*BLOCK_W-1:0] req_write_data;
    logic [1:0]           req_ready;
    logic [BLOCK_W-1:0]   req_read_data;
    logic                 grant_id;
    logic                 busy;
    logic                 mem_read;
    logic                 mem_write;
    logic [ADDR_W-1:0]    mem_addr;
    logic [BLOCK_W-1:0]   mem_write_data;
    logic [BLOCK_W-1:0]   mem_read_data;
    logic                 mem_ready;
`ifdef MEM_ARB_TIMEOUT_EN
    logic                 timeout_err;
`endif

    modport master (
`ifdef MEM_ARB_TIMEOUT_EN
        output timeout_err,
`endif
        input  req_read, req_write, req_addr, req_write_data,
        output req_ready, req_read_data, grant_id, busy,
        output mem_read, mem_write, mem_addr, mem_write_data,
        input  mem_read_data, mem_ready
    );

    modport slave (
`ifdef MEM_ARB_TIMEOUT_EN
        input  timeout_err,
`endif
        output req_read, req_write, req_addr, req_write_data,
        input  req_ready, req_read_data, grant_id, busy,
        input  mem_read, mem_write, mem_addr, mem_write_data,
        output mem_read_data, mem_ready
    );
endinterface

// File: rtl/mem_block_arbiter.sv
// Round-robin arbiter sharing one block-level main-memory port between the
// I-cache (requester 0) and the D-cache (requester 1). One block transaction
// is in flight at a time; the memory response is routed back to the winner.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_block_arbiter_if.master (request ports, memory port, status)
//
// Optional feature (macro MEM_ARB_TIMEOUT_EN): a watchdog in ISSUE abandons the
// memory request after TIMEOUT_CYCLES cycles without mem_ready, completes the
// transaction to the requester and pulses bus.timeout_err with req_ready.
//
// All outputs come straight from flops.
module mem_block_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned BLOCK_W        = 512,
    parameter int unsigned OFFSET_BITS    = 6
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
    input logic                 clk,
    input logic                 rst_n,
    mem_block_arbiter_if.master bus
);

    localparam logic [ADDR_W-1:0] OFFSET_MASK =
        {{(ADDR_W - OFFSET_BITS){1'b0}}, {OFFSET_BITS{1'b1}}};

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic                 ptr_q, ptr_d;
    logic                 grant_q, grant_d;
    logic                 op_write_q, op_write_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BLOCK_W-1:0]   wdata_q, wdata_d;
    logic [BLOCK_W-1:0]   rdata_q, rdata_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [1:0]           ready_q, ready_d;
    logic                 busy_q, busy_d;

    logic [1:0]           active;
    logic                 winner;
    logic [ADDR_W-1:0]    win_addr;
    logic [BLOCK_W-1:0]   win_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    assign active = bus.req_read | bus.req_write;

    // Round robin: the pointer holder wins if active, otherwise the other one.
    assign winner    = active[ptr_q] ? ptr_q : ~ptr_q;
    assign win_addr  = winner ? bus.req_addr[ADDR_W +: ADDR_W] : bus.req_addr[0 +: ADDR_W];
    assign win_wdata = winner ? bus.req_write_data[BLOCK_W +: BLOCK_W]
                              : bus.req_write_data[0 +: BLOCK_W];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        op_write_d  = op_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        ready_d     = 2'b00;
        busy_d      = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        tmo_d       = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                // mem_ready is deliberately ignored here.
                if (|active) begin
                    state_d     = StIssue;
                    grant_d     = winner;
                    addr_d      = win_addr & ~OFFSET_MASK;
                    wdata_d     = win_wdata;
                    // A requester asserting both read and write gets a write.
                    op_write_d  = bus.req_write[winner];
                    mem_write_d = bus.req_write[winner];
                    mem_read_d  = ~bus.req_write[winner];
                    busy_d      = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end

            StIssue: begin
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (bus.mem_ready) begin
                    if (!op_write_q) begin
                        rdata_d = bus.mem_read_data;
                    end
                    state_d     = StDone;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    ready_d     = grant_q ? 2'b10 : 2'b01;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d     = StDone;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    ready_d     = grant_q ? 2'b10 : 2'b01;
                    tmo_d       = 1'b1;
                end
`endif
            end

            StDone: begin
                state_d = StIdle;
                ptr_d   = ~grant_q;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            grant_q     <= 1'b0;
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            ready_q     <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            op_write_q  <= op_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign bus.timeout_err = tmo_q;
`endif

    assign bus.req_ready      = ready_q;
    assign bus.req_read_data  = rdata_q;
    assign bus.grant_id       = grant_q;
    assign bus.busy           = busy_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_write_data = wdata_q;

endmodule
